multicycle_ctrl_fsm: RTL and testbench

//  Main sequencing FSM for the multi-cycle RV32I core: walks each instruction through FETCH/DECODE/EXECUTE/MEM/WB.

---
 rtl/multicycle_ctrl_fsm_pkg.sv | 56 +++++
 rtl/multicycle_ctrl_fsm.sv | 169 ++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared definitions for the multi-cycle RV32I control sequencer:
// ALU operation classes, datapath mux encodings, opcodes and the state enum.
package multicycle_ctrl_fsm_pkg;

  // Operation class handed to alu_control
  localparam logic [1:0] ALU_OP_MEM  = 2'b00;
  localparam logic [1:0] ALU_OP_BEQ  = 2'b01;
  localparam logic [1:0] ALU_OP_MATH = 2'b10;

  // ALU operand A select
  localparam logic [1:0] SRC_A_PC   = 2'b00;
  localparam logic [1:0] SRC_A_RS1  = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  // Register file write-back select
  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  // RV32I major opcodes recognised by the sequencer
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Five bits leave spare encodings so a corrupted state has somewhere to recover from
  typedef enum logic [4:0] {
    S_IDLE     = 5'd0,
    S_FETCH    = 5'd1,
    S_DECODE   = 5'd2,
    S_EXEC_R   = 5'd3,
    S_EXEC_I   = 5'd4,
    S_MEM_ADDR = 5'd5,
    S_MEM_RD   = 5'd6,
    S_MEM_WR   = 5'd7,
    S_WB_ALU   = 5'd8,
    S_WB_MEM   = 5'd9,
    S_BRANCH   = 5'd10,
    S_JAL      = 5'd11,
    S_JALR     = 5'd12,
    S_LUI      = 5'd13,
    S_AUIPC    = 5'd14,
    S_TRAP     = 5'd15
  } state_t;

endpackage

// File: rtl/multicycle_ctrl_fsm.sv
// Main sequencing FSM of the multi-cycle RV32I core. Walks each instruction
// through fetch/decode/execute/memory/write-back, drives every datapath strobe,
// counts retired instructions and latches a sticky illegal-instruction trap.
module multicycle_ctrl_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       ctrl_alu_op,
  output logic             pc_src,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             illegal_insn,
  output logic [CNT_W-1:0] instret
);

  import multicycle_ctrl_fsm_pkg::*;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             illegal_q, illegal_d;
  logic             retire;

  // State, retire counter and trap flag; reset drops straight to idle so any open memory request vanishes at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state sequencing; decode dispatches on the held IR opcode, spare encodings fall back to idle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_REG:             state_d = S_EXEC_R;
          OP_IMM:             state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          OP_JAL:             state_d = S_JAL;
          OP_JALR:            state_d = S_JALR;
          OP_LUI:             state_d = S_LUI;
          OP_AUIPC:           state_d = S_AUIPC;
          default:            state_d = S_TRAP;
        endcase
      end
      S_EXEC_R:   state_d = S_WB_ALU;
      S_EXEC_I:   state_d = S_WB_ALU;
      S_MEM_ADDR: state_d = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) state_d = S_WB_MEM;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_WB_ALU:   state_d = S_FETCH;
      S_WB_MEM:   state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_FETCH;
      S_JALR:     state_d = S_FETCH;
      S_LUI:      state_d = S_WB_ALU;
      S_AUIPC:    state_d = S_WB_ALU;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_IDLE;
    endcase
  end

  // An instruction retires on any return to fetch except the idle-to-fetch start-up and a stalled fetch
  always_comb begin
    retire    = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_IDLE);
    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  // Strobe decode from the current state; only fetch qualifies IR/PC loads with the memory handshake
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RS2;
    ctrl_alu_op   = ALU_OP_MEM;
    pc_src        = 1'b0;
    reg_write     = 1'b0;
    wb_sel        = WB_ALUOUT;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRC_B_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = SRC_B_IMM;
      S_EXEC_R: begin
        alu_src_a   = SRC_A_RS1;
        ctrl_alu_op = ALU_OP_MATH;
      end
      S_EXEC_I: begin
        alu_src_a   = SRC_A_RS1;
        alu_src_b   = SRC_B_IMM;
        ctrl_alu_op = ALU_OP_MATH;
      end
      S_MEM_ADDR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      S_WB_ALU: reg_write = 1'b1;
      S_WB_MEM: begin
        reg_write = 1'b1;
        wb_sel    = WB_MDR;
      end
      S_BRANCH: begin
        alu_src_a     = SRC_A_RS1;
        ctrl_alu_op   = ALU_OP_BEQ;
        pc_write_cond = 1'b1;
        pc_src        = 1'b1;
      end
      S_JAL: begin
        reg_write = 1'b1;
        wb_sel    = WB_PC;
        pc_write  = 1'b1;
        pc_src    = 1'b1;
      end
      S_JALR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        reg_write = 1'b1;
        wb_sel    = WB_PC;
        pc_write  = 1'b1;
      end
      S_LUI: begin
        alu_src_a = SRC_A_ZERO;
        alu_src_b = SRC_B_IMM;
      end
      default: ;
    endcase
  end

  assign illegal_insn = illegal_q;
  assign instret      = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed, table-driven bench for the multi-cycle control FSM. A second
// instance with a 3-bit retire counter exposes counter wrap-around.
module tb_multicycle_ctrl_fsm;

  // Opcodes as the bench knows them
  localparam logic [6:0] T_ADD   = 7'b0110011;
  localparam logic [6:0] T_ADDI  = 7'b0010011;
  localparam logic [6:0] T_LW    = 7'b0000011;
  localparam logic [6:0] T_SW    = 7'b0100011;
  localparam logic [6:0] T_BEQ   = 7'b1100011;
  localparam logic [6:0] T_JAL   = 7'b1101111;
  localparam logic [6:0] T_JALR  = 7'b1100111;
  localparam logic [6:0] T_LUI   = 7'b0110111;
  localparam logic [6:0] T_AUIPC = 7'b0010111;
  localparam logic [6:0] T_BAD   = 7'b1111111;

  // Expected strobe words, field order:
  // mem_req mem_we iord ir_write pc_write pc_write_cond pc_src reg_write illegal | src_a src_b alu_op wb_sel
  localparam logic [16:0] E_IDLE     = {9'b000000000, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [16:0] E_FETCH    = {9'b100110000, 2'b00, 2'b01, 2'b00, 2'b00};
  localparam logic [16:0] E_FWAIT    = {9'b100000000, 2'b00, 2'b01, 2'b00, 2'b00};
  localparam logic [16:0] E_DECODE   = {9'b000000000, 2'b00, 2'b10, 2'b00, 2'b00};
  localparam logic [16:0] E_EXEC_R   = {9'b000000000, 2'b01, 2'b00, 2'b10, 2'b00};
  localparam logic [16:0] E_EXEC_I   = {9'b000000000, 2'b01, 2'b10, 2'b10, 2'b00};
  localparam logic [16:0] E_MEM_ADDR = {9'b000000000, 2'b01, 2'b10, 2'b00, 2'b00};
  localparam logic [16:0] E_MEM_RD   = {9'b101000000, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [16:0] E_MEM_WR   = {9'b111000000, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [16:0] E_WB_ALU   = {9'b000000010, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [16:0] E_WB_MEM   = {9'b000000010, 2'b00, 2'b00, 2'b00, 2'b01};
  localparam logic [16:0] E_BRANCH   = {9'b000001100, 2'b01, 2'b00, 2'b01, 2'b00};
  localparam logic [16:0] E_JAL      = {9'b000010110, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [16:0] E_JALR     = {9'b000010010, 2'b01, 2'b10, 2'b00, 2'b10};
  localparam logic [16:0] E_LUI      = {9'b000000000, 2'b10, 2'b10, 2'b00, 2'b00};
  localparam logic [16:0] E_AUIPC    = {9'b000000000, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [16:0] E_TRAP     = {9'b000000001, 2'b00, 2'b00, 2'b00, 2'b00};

  typedef struct {
    string       name;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic [16:0] exp;
    logic [31:0] instret;
  } vec_t;

  logic        clk, rst, mem_ready;
  logic [6:0]  opcode;
  logic        mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src, reg_write, illegal_insn;
  logic [1:0]  alu_src_a, alu_src_b, ctrl_alu_op, wb_sel;
  logic [31:0] instret;
  logic        w_mem_req, w_mem_we, w_iord, w_ir_write, w_pc_write, w_pc_write_cond, w_pc_src, w_reg_write, w_illegal;
  logic [1:0]  w_alu_src_a, w_alu_src_b, w_alu_op, w_wb_sel;
  logic [2:0]  w_instret;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  multicycle_ctrl_fsm #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ctrl_alu_op(ctrl_alu_op), .pc_src(pc_src),
    .reg_write(reg_write), .wb_sel(wb_sel), .illegal_insn(illegal_insn), .instret(instret)
  );

  multicycle_ctrl_fsm #(.CNT_W(3)) dut_wrap (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(w_mem_req), .mem_we(w_mem_we), .iord(w_iord), .ir_write(w_ir_write),
    .pc_write(w_pc_write), .pc_write_cond(w_pc_write_cond), .alu_src_a(w_alu_src_a),
    .alu_src_b(w_alu_src_b), .ctrl_alu_op(w_alu_op), .pc_src(w_pc_src),
    .reg_write(w_reg_write), .wb_sel(w_wb_sel), .illegal_insn(w_illegal), .instret(w_instret)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after the falling edge so they settle well before the next rising edge
  task automatic applyStimulus(input logic [6:0] op, input logic rdy);
    @(negedge clk);
    opcode    = op;
    mem_ready = rdy;
    #1;
  endtask

  // Compares both instances against the expected strobe word and retire count
  task automatic checkOutput(input string name, input logic [16:0] exp, input logic [31:0] exp_cnt);
    logic [16:0] act, act_w;
    logic [2:0]  exp_w;
    act   = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src, reg_write, illegal_insn,
             alu_src_a, alu_src_b, ctrl_alu_op, wb_sel};
    act_w = {w_mem_req, w_mem_we, w_iord, w_ir_write, w_pc_write, w_pc_write_cond, w_pc_src, w_reg_write,
             w_illegal, w_alu_src_a, w_alu_src_b, w_alu_op, w_wb_sel};
    exp_w = exp_cnt[2:0];
    checks += 3;
    if (act !== exp || act_w !== exp) begin
      errors++;
      $display("[TB] FAIL %s strobes: got %b / %b, expected %b", name, act, act_w, exp);
    end
    if (instret !== exp_cnt) begin
      errors++;
      $display("[TB] FAIL %s instret: got %0d, expected %0d", name, instret, exp_cnt);
    end
    if (w_instret !== exp_w) begin
      errors++;
      $display("[TB] FAIL %s instret wrap: got %0d, expected %0d", name, w_instret, exp_w);
    end
  endtask

  function automatic void addVec(input string n, input logic [6:0] op, input logic rdy,
                                 input logic [16:0] e, input logic [31:0] cnt);
    vec_t v;
    v.name = n; v.opcode = op; v.mem_ready = rdy; v.exp = e; v.instret = cnt;
    vecs.push_back(v);
  endfunction

  initial begin
    // Zero-wait walk through every instruction class, then a load with 3 wait states per access
    addVec("add fetch", T_ADD, 1, E_FETCH, 0);     addVec("add decode", T_ADD, 1, E_DECODE, 0);
    addVec("add exec", T_ADD, 1, E_EXEC_R, 0);     addVec("add wb", T_ADD, 1, E_WB_ALU, 0);
    addVec("addi fetch", T_ADDI, 1, E_FETCH, 1);   addVec("addi decode", T_ADDI, 1, E_DECODE, 1);
    addVec("addi exec", T_ADDI, 1, E_EXEC_I, 1);   addVec("addi wb", T_ADDI, 1, E_WB_ALU, 1);
    addVec("lw fetch", T_LW, 1, E_FETCH, 2);       addVec("lw decode", T_LW, 1, E_DECODE, 2);
    addVec("lw addr", T_LW, 1, E_MEM_ADDR, 2);     addVec("lw read", T_LW, 1, E_MEM_RD, 2);
    addVec("lw wb", T_LW, 1, E_WB_MEM, 2);
    addVec("sw fetch", T_SW, 1, E_FETCH, 3);       addVec("sw decode", T_SW, 1, E_DECODE, 3);
    addVec("sw addr", T_SW, 1, E_MEM_ADDR, 3);     addVec("sw write", T_SW, 1, E_MEM_WR, 3);
    addVec("beq fetch", T_BEQ, 1, E_FETCH, 4);     addVec("beq decode", T_BEQ, 1, E_DECODE, 4);
    addVec("beq compare", T_BEQ, 1, E_BRANCH, 4);
    addVec("jal fetch", T_JAL, 1, E_FETCH, 5);     addVec("jal decode", T_JAL, 1, E_DECODE, 5);
    addVec("jal link", T_JAL, 1, E_JAL, 5);
    addVec("jalr fetch", T_JALR, 1, E_FETCH, 6);   addVec("jalr decode", T_JALR, 1, E_DECODE, 6);
    addVec("jalr link", T_JALR, 1, E_JALR, 6);
    addVec("lui fetch", T_LUI, 1, E_FETCH, 7);     addVec("lui decode", T_LUI, 1, E_DECODE, 7);
    addVec("lui exec", T_LUI, 1, E_LUI, 7);        addVec("lui wb", T_LUI, 1, E_WB_ALU, 7);
    addVec("auipc fetch", T_AUIPC, 1, E_FETCH, 8); addVec("auipc decode", T_AUIPC, 1, E_DECODE, 8);
    addVec("auipc hold", T_AUIPC, 1, E_AUIPC, 8);  addVec("auipc wb", T_AUIPC, 1, E_WB_ALU, 8);
    addVec("lw slow fetch w1", T_LW, 0, E_FWAIT, 9);  addVec("lw slow fetch w2", T_LW, 0, E_FWAIT, 9);
    addVec("lw slow fetch w3", T_LW, 0, E_FWAIT, 9);  addVec("lw slow fetch rdy", T_LW, 1, E_FETCH, 9);
    addVec("lw slow decode", T_LW, 0, E_DECODE, 9);   addVec("lw slow addr", T_LW, 0, E_MEM_ADDR, 9);
    addVec("lw slow read w1", T_LW, 0, E_MEM_RD, 9);  addVec("lw slow read w2", T_LW, 0, E_MEM_RD, 9);
    addVec("lw slow read w3", T_LW, 0, E_MEM_RD, 9);  addVec("lw slow read rdy", T_LW, 1, E_MEM_RD, 9);
    addVec("lw slow wb", T_LW, 0, E_WB_MEM, 9);

    // Reset held for three cycles with a ready memory, then released into idle
    rst = 1'b1; opcode = 7'd0; mem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      checkOutput("reset hold", E_IDLE, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("idle after reset", E_IDLE, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].opcode, vecs[i].mem_ready);
      checkOutput(vecs[i].name, vecs[i].exp, vecs[i].instret);
    end

    // Unsupported opcode traps and stays trapped with memory quiet, even with mem_ready high
    applyStimulus(T_BAD, 1);
    checkOutput("bad fetch", E_FETCH, 10);
    applyStimulus(T_BAD, 0);
    checkOutput("bad decode", E_DECODE, 10);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(T_BAD, 1);
      checkOutput("trap hold", E_TRAP, 10);
    end

    // Reset clears the sticky trap and the counter asynchronously
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("trap cleared by reset", E_IDLE, 0);
    @(negedge clk);
    rst = 1'b0; opcode = T_LW; mem_ready = 1'b0;
    #1;
    checkOutput("idle after trap reset", E_IDLE, 0);

    // Reset in the middle of a pending load read drops mem_req without waiting for a clock edge
    applyStimulus(T_LW, 1);
    checkOutput("abort fetch", E_FETCH, 0);
    applyStimulus(T_LW, 0);
    checkOutput("abort decode", E_DECODE, 0);
    applyStimulus(T_LW, 0);
    checkOutput("abort addr", E_MEM_ADDR, 0);
    applyStimulus(T_LW, 0);
    checkOutput("abort read pending", E_MEM_RD, 0);
    #2;
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    checkOutput("abort read reset", E_IDLE, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("late ready ignored", E_IDLE, 0);
    applyStimulus(T_LW, 1);
    checkOutput("restart fetch", E_FETCH, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
